// File: rtl/dpram_arb_pkg.sv
// Shared defaults and width helpers for the port-A arbiter of the dual-port RAM.
package dpram_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Requester ids need at least one bit even for a degenerate single requester.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester, RAM port-A and response signals of the arbiter, bundled as one interface.
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ram_we;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_WIDTH-1:0]         ram_rdata;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_we;
  logic [DATA_WIDTH-1:0]         rsp_data;

  // Environment side: requesters plus the RAM read-data return.
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    input  req_ready, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_id, rsp_we, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    output req_ready, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_id, rsp_we, rsp_data
  );

endinterface

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning from ptr upward, wrapping.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_grant_id,
  output logic                o_any
);

  // Priority scan over the rotated request vector.
  always_comb begin
    logic found;
    logic hit;
    int   idx;
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    hit        = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx          = (int'(i_ptr) + k) % NUM_REQ;
      hit          = !found && i_req[idx];
      o_grant[idx] = hit;
      o_grant_id   = hit ? ID_WIDTH'(idx) : o_grant_id;
      found        = found | hit;
    end
    o_any = found;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares RAM port A among NUM_REQ requesters: round-robin with lockable bursts,
// combinational RAM-side muxing and a response registered one cycle after accept.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  dpram_port_arbiter_if.slave bus
);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic                  r_lock_act;
  logic [ID_WIDTH-1:0]   r_lock_id;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic                  r_rsp_we;

  logic [NUM_REQ-1:0]    w_rr_grant;
  logic [ID_WIDTH-1:0]   w_rr_id;
  logic                  w_rr_any;
  logic                  w_lock_hit;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic                  w_accept;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .i_req      (bus.req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_rr_grant),
    .o_grant_id (w_rr_id),
    .o_any      (w_rr_any)
  );

  assign w_lock_hit = r_lock_act && bus.req_valid[r_lock_id];

  // Grant selection: a live lock owner beats the round-robin pick; nothing is granted in reset.
  always_comb begin
    w_ready  = '0;
    w_gnt_id = '0;
    w_accept = 1'b0;
    if (!rst_n) begin
      w_accept = 1'b0;
    end else if (w_lock_hit) begin
      w_gnt_id           = r_lock_id;
      w_ready[r_lock_id] = 1'b1;
      w_accept           = 1'b1;
    end else begin
      w_gnt_id = w_rr_id;
      w_ready  = w_rr_grant;
      w_accept = w_rr_any;
    end
  end

  // Port-A field mux: granted requester's op, otherwise all zero.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (w_accept) begin
      w_ram_we    = bus.req_we[w_gnt_id];
      w_ram_addr  = bus.req_addr[int'(w_gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      w_ram_wdata = bus.req_wdata[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_ram_we    = 1'b0;
    end
  end

  // Rotation pointer, lock state and response registers; a gap in grants always drops the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_lock_act  <= 1'b0;
      r_lock_id   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_we    <= 1'b0;
    end else if (w_accept) begin
      r_ptr       <= (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);
      r_lock_act  <= bus.req_lock[w_gnt_id];
      r_lock_id   <= w_gnt_id;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_id;
      r_rsp_we    <= w_ram_we;
    end else begin
      r_lock_act  <= 1'b0;
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_we    = r_rsp_we;
  // RAM output is already registered, so it lines up with the response strobe.
  assign bus.rsp_data  = bus.ram_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a read-before-write RAM model on port A.
module tb_dpram_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  dpram_port_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4), .ID_WIDTH(2)) bus ();

  dpram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4), .ID_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read of the old word, write lands at the same edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      bus.ram_rdata <= 8'h00;
    end else begin
      bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive requests, check grant, port-A fields and the previous op's response.
  task automatic op_step(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                         input logic [3:0] exp_rdy, input bit exp_rv, input logic [1:0] exp_rid,
                         input bit exp_rwe, input logic [7:0] exp_rdata);
    logic [3:0] ea;
    logic [7:0] ed;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    ea = 4'h0;
    ed = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        ea = bus.req_addr[i*4 +: 4];
        ed = bus.req_wdata[i*8 +: 8];
      end
    end
    @(negedge clk);
    check_eq("req_ready", bus.req_ready, exp_rdy);
    check_eq("ram_we", bus.ram_we, |(exp_rdy & we));
    check_eq("ram_addr", bus.ram_addr, ea);
    check_eq("ram_wdata", bus.ram_wdata, ed);
    check_eq("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv) begin
      check_eq("rsp_id", bus.rsp_id, exp_rid);
      check_eq("rsp_we", bus.rsp_we, exp_rwe);
      check_eq("rsp_data", bus.rsp_data, exp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_we    = 4'b1111;
    bus.req_lock  = 4'b0000;
    bus.req_addr  = 16'h3210;
    bus.req_wdata = 32'h44332211;

    // reset with all requesters valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 4'b0000);
    check_eq("rst_ram_we", bus.ram_we, 1'b0);
    check_eq("rst_ram_addr", bus.ram_addr, 4'h0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_id", bus.rsp_id, 2'd0);
    check_eq("rst_rsp_we", bus.rsp_we, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // rotation 0,1,2,3,0,1,2,3 (reads of addr i -> 8'h10+i)
    for (int k = 0; k < 8; k++) begin
      op_step(4'b1111, 4'b0000, 4'b0000, 4'(1 << (k % 4)), k > 0,
              2'((k + 3) % 4), 1'b0, 8'h10 + 8'((k + 3) % 4));
    end

    // idle gap: last response drains, then nothing
    op_step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 8'h13);
    op_step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

    // write A5 to addr 3 by req0, then read it back by req2 (ptr still 0 after the gap)
    bus.req_addr  = 16'h0303;
    bus.req_wdata = 32'h000000A5;
    op_step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 8'h00);
    op_step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd0, 1'b1, 8'h13);

    // wrap: ptr=3 finds req0; then ptr=1 scans 1,2,3 and finds req3
    op_step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd2, 1'b0, 8'hA5);
    op_step(4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd0, 1'b0, 8'hA5);

    // lock burst by req1: three grants to 1, then rotation resumes at 2
    bus.req_addr = 16'h3210;
    op_step(4'b1111, 4'b0000, 4'b0010, 4'b0001, 1'b1, 2'd3, 1'b0, 8'h10);
    op_step(4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd0, 1'b0, 8'h10);
    op_step(4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h11);
    op_step(4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h11);
    op_step(4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd1, 1'b0, 8'h11);

    // lock taken by req1, then a one-cycle gap must drop it (next grant from ptr=2)
    op_step(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, 2'd2, 1'b0, 8'h12);
    op_step(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 8'h11);
    op_step(4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0, 8'h00);

    // reset mid-op: the response of the just-accepted op is discarded
    op_step(4'b1111, 4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd2, 1'b0, 8'h12);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", bus.req_ready, 4'b0000);
    check_eq("midrst_ram_we", bus.ram_we, 1'b0);
    check_eq("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op_step(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
